// File: rtl/kronos_dmem_arb.sv
// rtl/kronos_dmem_arb.sv - two-requester round-robin arbiter sharing one 1-cycle data SRAM
module kronos_dmem_arb #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [31:0]   r0_addr,
    input  logic [31:0]   r0_wr_data,
    input  logic [3:0]    r0_wr_mask,
    input  logic          r0_rd_req,
    input  logic          r0_wr_req,
    output logic          r0_gnt,
    output logic [31:0]   r0_rd_data,

    input  logic [31:0]   r1_addr,
    input  logic [31:0]   r1_wr_data,
    input  logic [3:0]    r1_wr_mask,
    input  logic          r1_rd_req,
    input  logic          r1_wr_req,
    output logic          r1_gnt,
    output logic [31:0]   r1_rd_data,

    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wr_mask,
    output logic          mem_en,
    output logic          mem_wr_en,
    input  logic [31:0]   mem_rdata
);

    logic req0, req1;
    logic elig0, elig1;
    logic win0, win1;
    logic gnt0_q, gnt0_d;
    logic gnt1_q, gnt1_d;
    logic prio_q, prio_d;

    // Byte-offset bits and bits above the SRAM depth carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{r0_addr[1:0], r0_addr[31:AW+2],
                                r1_addr[1:0], r1_addr[31:AW+2]};

    // Pick at most one winner; a requester in its gnt cycle is ineligible so a
    // held request is not accepted twice, and nothing is accepted during reset.
    always_comb begin
        req0   = r0_rd_req | r0_wr_req;
        req1   = r1_rd_req | r1_wr_req;
        elig0  = req0 & ~gnt0_q & ~rst;
        elig1  = req1 & ~gnt1_q & ~rst;
        win0   = elig0 & (~elig1 | ~prio_q);
        win1   = elig1 & (~elig0 |  prio_q);
        gnt0_d = win0;
        gnt1_d = win1;
        prio_d = prio_q;
        if (win0) begin
            prio_d = 1'b1;
        end else if (win1) begin
            prio_d = 1'b0;
        end
    end

    // Steer the winner's access onto the SRAM; requester 0 fields when idle.
    always_comb begin
        mem_en      = win0 | win1;
        mem_addr    = r0_addr[2 +: AW];
        mem_wdata   = r0_wr_data;
        mem_wr_mask = r0_wr_mask;
        mem_wr_en   = win0 & r0_wr_req;
        if (win1) begin
            mem_addr    = r1_addr[2 +: AW];
            mem_wdata   = r1_wr_data;
            mem_wr_mask = r1_wr_mask;
            mem_wr_en   = r1_wr_req;
        end
    end

    // Grant flags and the round-robin pointer; reset cancels any pending gnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            prio_q <= 1'b0;
        end else begin
            gnt0_q <= gnt0_d;
            gnt1_q <= gnt1_d;
            prio_q <= prio_d;
        end
    end

    assign r0_gnt     = gnt0_q;
    assign r1_gnt     = gnt1_q;
    assign r0_rd_data = gnt0_q ? mem_rdata : 32'h0;
    assign r1_rd_data = gnt1_q ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_kronos_dmem_arb.sv
// tb/tb_kronos_dmem_arb.sv - self-checking bench for kronos_dmem_arb
module tb_kronos_dmem_arb;

    localparam int AW    = 8;
    localparam int N_RND = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   r0_addr, r0_wr_data, r1_addr, r1_wr_data;
    logic [3:0]    r0_wr_mask, r1_wr_mask;
    logic          r0_rd_req, r0_wr_req, r1_rd_req, r1_wr_req;
    logic          r0_gnt, r1_gnt;
    logic [31:0]   r0_rd_data, r1_rd_data;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wr_mask;
    logic          mem_en, mem_wr_en;
    logic [31:0]   mem_rdata;

    kronos_dmem_arb #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .r0_addr(r0_addr), .r0_wr_data(r0_wr_data), .r0_wr_mask(r0_wr_mask),
        .r0_rd_req(r0_rd_req), .r0_wr_req(r0_wr_req), .r0_gnt(r0_gnt), .r0_rd_data(r0_rd_data),
        .r1_addr(r1_addr), .r1_wr_data(r1_wr_data), .r1_wr_mask(r1_wr_mask),
        .r1_rd_req(r1_rd_req), .r1_wr_req(r1_wr_req), .r1_gnt(r1_gnt), .r1_rd_data(r1_rd_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_mask(mem_wr_mask),
        .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM: 1-cycle read latency, mask bit set = byte not written.
    logic [31:0] sram [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) sram[i] <= (i == 5) ? 32'hDEADBEEF : 32'h0;
            mem_rdata <= 32'h0;
        end else if (mem_en) begin
            if (mem_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (!mem_wr_mask[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] ref_mem [256];
    logic        turn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic note_win(input logic w);
        turn = ~w;
    endtask

    task automatic ref_write(input int ix, input logic [31:0] d, input logic [3:0] m);
        for (int b = 0; b < 4; b++)
            if (!m[b]) ref_mem[ix][8*b +: 8] = d[8*b +: 8];
    endtask

    // Random-phase requester state
    logic        act [2];
    logic        acc [2];
    logic        q_wr [2];
    logic        q_both [2];
    logic [31:0] q_addr [2];
    logic [31:0] q_data [2];
    logic [3:0]  q_mask [2];
    logic [7:0]  q_idx [2];
    int          wait_c [2];

    task automatic drive_ports;
        r0_addr    = q_addr[0];  r0_wr_data = q_data[0];  r0_wr_mask = q_mask[0];
        r0_wr_req  = act[0] & q_wr[0];
        r0_rd_req  = act[0] & (~q_wr[0] | q_both[0]);
        r1_addr    = q_addr[1];  r1_wr_data = q_data[1];  r1_wr_mask = q_mask[1];
        r1_wr_req  = act[1] & q_wr[1];
        r1_rd_req  = act[1] & (~q_wr[1] | q_both[1]);
    endtask

    initial begin
        int n0, n1, issued, done, cyc, w;
        logic w_exp;
        logic e [2];
        logic [31:0] rd, a;

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        ref_mem[5] = 32'hDEADBEEF;
        turn = 1'b0;

        // Reset with both requesters asking
        rst = 1'b1;
        r0_addr = 32'h4; r0_wr_data = 32'h0; r0_wr_mask = 4'h0; r0_rd_req = 1'b1; r0_wr_req = 1'b0;
        r1_addr = 32'h8; r1_wr_data = 32'h0; r1_wr_mask = 4'h0; r1_rd_req = 1'b1; r1_wr_req = 1'b0;
        repeat (4) begin
            tick;
            check("rst_r0_gnt", r0_gnt, 0);
            check("rst_r1_gnt", r1_gnt, 0);
            check("rst_mem_en", mem_en, 0);
            check("rst_r0_rd_data", r0_rd_data, 0);
        end
        rst = 1'b0;
        #1;
        check("first_win_en", mem_en, 1);
        check("first_win_addr", mem_addr, 1);
        note_win(1'b0);
        tick;
        check("first_r0_gnt", r0_gnt, 1);
        check("first_r1_gnt", r1_gnt, 0);
        r0_rd_req = 1'b0;
        #1;
        check("second_win_addr", mem_addr, 2);
        note_win(1'b1);
        tick;
        check("second_r1_gnt", r1_gnt, 1);
        check("second_r0_gnt", r0_gnt, 0);
        r1_rd_req = 1'b0;
        #1;
        check("idle_mem_en", mem_en, 0);
        tick;

        // Single read of preloaded word 5
        r0_addr = 32'h14; r0_rd_req = 1'b1;
        #1;
        check("rd_mem_en", mem_en, 1);
        check("rd_mem_addr", mem_addr, 5);
        check("rd_mem_wr_en", mem_wr_en, 0);
        note_win(1'b0);
        tick;
        check("rd_r0_gnt", r0_gnt, 1);
        check("rd_r0_data", r0_rd_data, 32'hDEADBEEF);
        check("rd_r1_gnt", r1_gnt, 0);
        check("rd_r1_data", r1_rd_data, 0);
        r0_rd_req = 1'b0;
        #1;
        check("rd_after_en", mem_en, 0);
        tick;
        check("rd_gnt_once", r0_gnt, 0);

        // r1 write then read back with a request held through its gnt cycle
        r1_addr = 32'h3C; r1_wr_data = 32'h12345678; r1_wr_mask = 4'b0000; r1_wr_req = 1'b1;
        #1;
        check("wr_mem_en", mem_en, 1);
        check("wr_mem_wr_en", mem_wr_en, 1);
        check("wr_mem_addr", mem_addr, 15);
        check("wr_mem_wdata", mem_wdata, 32'h12345678);
        note_win(1'b1);
        tick;
        check("wr_r1_gnt", r1_gnt, 1);
        ref_write(15, 32'h12345678, 4'b0000);
        r1_wr_req = 1'b0; r1_rd_req = 1'b1;
        #1;
        check("held_ineligible_en", mem_en, 0);
        tick;
        check("held_no_gnt", r1_gnt, 0);
        #1;
        check("rb_mem_en", mem_en, 1);
        check("rb_mem_wr_en", mem_wr_en, 0);
        note_win(1'b1);
        tick;
        check("rb_r1_gnt", r1_gnt, 1);
        check("rb_r1_data", r1_rd_data, ref_mem[15]);
        r1_rd_req = 1'b0;
        tick;

        // Both strobes on r0 act as a masked write
        r0_addr = 32'h20; r0_wr_data = 32'hCAFEF00D; r0_wr_mask = 4'b0011;
        r0_rd_req = 1'b1; r0_wr_req = 1'b1;
        #1;
        check("both_mem_wr_en", mem_wr_en, 1);
        check("both_mem_mask", mem_wr_mask, 4'b0011);
        check("both_mem_addr", mem_addr, 8);
        note_win(1'b0);
        tick;
        check("both_r0_gnt", r0_gnt, 1);
        ref_write(8, 32'hCAFEF00D, 4'b0011);
        r0_rd_req = 1'b0; r0_wr_req = 1'b0;
        tick;
        r0_rd_req = 1'b1;
        #1;
        note_win(1'b0);
        tick;
        check("mask_rb_data", r0_rd_data, ref_mem[8]);
        r0_rd_req = 1'b0;
        tick;

        // Contention: both hold reads for 20 acceptances
        r0_addr = 32'h0C; r1_addr = 32'h14; r0_rd_req = 1'b1; r1_rd_req = 1'b1;
        n0 = 0; n1 = 0;
        w_exp = turn;
        for (int k = 0; k < 20; k++) begin
            #1;
            check("cont_mem_en", mem_en, 1);
            check("cont_mem_addr", mem_addr, w_exp ? 5 : 3);
            note_win(w_exp);
            tick;
            check("cont_winner_gnt", w_exp ? r1_gnt : r0_gnt, 1);
            check("cont_loser_gnt", w_exp ? r0_gnt : r1_gnt, 0);
            check("cont_rd_data", w_exp ? r1_rd_data : r0_rd_data, ref_mem[w_exp ? 5 : 3]);
            n0 += int'(r0_gnt);
            n1 += int'(r1_gnt);
            w_exp = ~w_exp;
        end
        check("cont_r0_count", n0, 10);
        check("cont_r1_count", n1, 10);
        r0_rd_req = 1'b0; r1_rd_req = 1'b0;
        #1;
        check("cont_end_en", mem_en, 0);
        tick;
        tick;

        // Randomized traffic against the scoreboard memory
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; acc[i] = 1'b0; q_wr[i] = 1'b0; q_both[i] = 1'b0;
            q_addr[i] = 32'h0; q_data[i] = 32'h0; q_mask[i] = 4'h0; q_idx[i] = 8'h0; wait_c[i] = 0;
        end
        drive_ports();
        issued = 0; done = 0; cyc = 0;
        while (done < N_RND && cyc < 20000) begin
            check("rnd_r0_gnt", r0_gnt, acc[0]);
            check("rnd_r1_gnt", r1_gnt, acc[1]);
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    rd = (i == 1) ? r1_rd_data : r0_rd_data;
                    if (q_wr[i]) ref_write(q_idx[i], q_data[i], q_mask[i]);
                    else check("rnd_rd_data", rd, ref_mem[q_idx[i]]);
                    check("rnd_latency", wait_c[i] <= 2, 1);
                    act[i] = 1'b0;
                    done++;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (!act[i] && issued < N_RND && $urandom_range(0, 3) != 0) begin
                    act[i]    = 1'b1;
                    issued++;
                    q_idx[i]  = 8'($urandom_range(0, 15));
                    a         = $urandom;
                    a[2 +: 8] = q_idx[i];
                    q_addr[i] = a;
                    q_wr[i]   = $urandom_range(0, 1) == 1;
                    q_both[i] = $urandom_range(0, 3) == 0;
                    q_data[i] = $urandom;
                    q_mask[i] = 4'($urandom_range(0, 15));
                    wait_c[i] = 0;
                end
            end
            drive_ports();
            for (int i = 0; i < 2; i++) e[i] = act[i] & ~acc[i];
            if (e[0] && e[1]) w = int'(turn);
            else if (e[0])    w = 0;
            else if (e[1])    w = 1;
            else              w = -1;
            for (int i = 0; i < 2; i++) begin
                if (e[i]) wait_c[i]++;
                acc[i] = (w == i);
            end
            #1;
            check("rnd_mem_en", mem_en, w >= 0);
            if (w >= 0) begin
                check("rnd_mem_addr", mem_addr, q_idx[w]);
                check("rnd_mem_wr_en", mem_wr_en, q_wr[w]);
                if (q_wr[w]) begin
                    check("rnd_mem_wdata", mem_wdata, q_data[w]);
                    check("rnd_mem_mask", mem_wr_mask, q_mask[w]);
                end
                note_win(w[0]);
            end
            tick;
            cyc++;
        end
        check("rnd_all_done", done, N_RND);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/kronos_dmem_arb.md
# kronos_dmem_arb

Two-requester arbiter that shares one single-port, 1-cycle-latency 32b data SRAM between the Kronos write-back stage (requester 0) and a secondary master (requester 1, e.g. debug/DMA loader). It accepts at most one word access per cycle and multiplexes requester address, data and strobes onto the SRAM. It returns a registered one-cycle `gnt` pulse to the winner, with read data valid in that same cycle. Requesters use the core's existing rd_req/wr_req/gnt protocol unchanged.

## Interface
- `AW`, 8: SRAM word-address width; SRAM depth is 2**AW words.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: synchronous reset, active-high.
- `r0_addr`, `r1_addr` input 32 each: byte address. Bits [1:0] are ignored and [2+:AW] are used.
- `r0_wr_data`, `r1_wr_data` input 32 each: write data.
- `r0_wr_mask`, `r1_wr_mask` input 4 each: byte mask passed through to SRAM.
- `r0_rd_req`, `r1_rd_req` input 1 each: read request, held until gnt.
- `r0_wr_req`, `r1_wr_req` input 1 each: write request, held until gnt.
- `r0_gnt`, `r1_gnt` output 1 each: one-cycle completion pulse.
- `r0_rd_data`, `r1_rd_data` output 32 each: read data, valid when the matching gnt is high.
- `mem_addr` output AW: SRAM word address.
- `mem_wdata` output 32: SRAM write data.
- `mem_wr_mask` output 4: SRAM byte mask.
- `mem_en` output 1: SRAM access enable.
- `mem_wr_en` output 1: SRAM write enable.
- `mem_rdata` input 32: SRAM read data, valid the cycle after an enabled read.

## Operation
- Request of requester i: `ri_req = ri_rd_req | ri_wr_req`. If both strobes are high, the access is a write.
- Eligibility: requester i is eligible when `ri_req` is high and `ri_gnt_q` (its accepted-last-cycle flag) is low. This prevents re-accepting a held request in its gnt cycle.
- Arbitration (combinational, each cycle):
  - One eligible requester: it wins.
  - Both eligible: the requester named by the priority pointer `prio` wins.
- On a win:
  - `mem_en` = 1.
  - `mem_wr_en` = winner write.
  - `mem_addr`, `mem_wdata` and `mem_wr_mask` come from the winner.
  - `prio` updates to the loser at the next edge (round-robin).
  - `ri_gnt_q` for the winner is set at the next edge.
- No winner: `mem_en` = 0, `mem_wr_en` = 0. The muxed fields hold requester 0 values (don't care). `prio` holds.
- Gnt cycle:
  - `ri_gnt` = `ri_gnt_q`.
  - `ri_rd_data` = `mem_rdata` for both reads and writes. Write read-data is don't care, but the bench sees the SRAM output.
  - The non-granted requester's `rd_data` is 0.
- A request deasserted before acceptance is dropped silently. Once accepted, gnt always issues the next cycle.
- At most one `gnt` is high per cycle, because only one access is accepted per cycle.
- The block does no byte lane extraction and no misalignment splitting. Both are the requester's job.

## Timing
- Reset values:
  - `r0_gnt` = `r1_gnt` = 0; `ri_gnt_q` = 0.
  - `prio` = 0 (requester 0 favoured).
  - `mem_en` = `mem_wr_en` = 0, since no requester is eligible while `rst` is high.
  - `r0_rd_data` = `r1_rd_data` = 0.
- Reset mid-operation: a pending gnt is cancelled. A write already presented to the SRAM on that edge may have completed.
- Latency: a request seen at edge N with no contention gives gnt and rd_data at edge N+1. This matches the core's existing req→gnt bench model.
- Throughput:
  - SRAM can be busy every cycle under contention, alternating r0, r1, r0, …
  - A single requester issuing back-to-back accesses gets one access per 2 cycles. Its req stays high through the gnt cycle and is ineligible that cycle.
- Contention: the loser's request must remain asserted; it is served no later than 1 cycle after the winner's acceptance.
- No combinational path from `mem_rdata` to any state; `gnt` is purely registered.

## Test plan
- Reset:
  - Drive `rst` = 1 for 4 cycles with both requesters requesting → both gnt = 0 and `mem_en` = 0 throughout.
  - After release, r0 wins first (`prio` = 0).
- Single read:
  - Preload SRAM word 5 = 0xDEADBEEF; r0 reads addr 0x14 → `mem_en` = 1, `mem_addr` = 5 at cycle N.
  - `r0_gnt` = 1 and `r0_rd_data` = 0xDEADBEEF at N+1 only; `r1_gnt` stays 0.
- Write then read:
  - r1 writes 0x12345678 to addr 0x3C with mask 4'b0 → `mem_wr_en` = 1, `mem_addr` = 15.
  - A subsequent r1 read of 0x3C returns 0x12345678 with `r1_gnt` one cycle after acceptance.
- Contention:
  - Both request continuously for 20 cycles → `mem_en` = 1 every cycle; grants alternate r0, r1, r0, ….
  - 10 grants each, never both in one cycle.
- Simultaneous rd and wr strobes on r0 → treated as a write (`mem_wr_en` = 1).
- Randomized: 1024 random r0/r1 reads and writes against a scoreboard memory model → every read returns the last written value.
  - Every `mem_addr[1:0]`-derived address is word-aligned.
  - Every request is granted within 2 cycles.
